// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-side signal bundle for ram_arbiter
// Signals:
//   m0_*/m1_* : requester handshake (req, wr, addr, wdata in; gnt, rvalid, rdata out)
//   ram_*     : single-port synchronous RAM pins (addr, wdata, wr out; rdata in)
// Modports:
//   slave  : arbiter view
//   master : requester / RAM environment view
interface ram_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_wr;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_wr;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_wr;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  m0_req, m0_wr, m0_addr, m0_wdata,
      input  m1_req, m1_wr, m1_addr, m1_wdata,
      input  ram_rdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output ram_addr, ram_wdata, ram_wr
   );

   modport master (
      output m0_req, m0_wr, m0_addr, m0_wdata,
      output m1_req, m1_wr, m1_addr, m1_wdata,
      output ram_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  ram_addr, ram_wdata, ram_wr
   );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter and sequencer for a 2K x 32 single-port RAM
// Ports:
//   clk   : clock, all logic on rising edge
//   rst_n : synchronous active-low reset
//   bus   : ram_arbiter_if.slave (m0/m1 handshakes and RAM pins), all outputs registered
// Build option:
//   RAM_ARB_FIXED_PRIO_EN : m0 always wins a tie (m1 may starve); default is round-robin
module ram_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_win;        // 0 = m0 owns the access in flight, 1 = m1
   logic              w_pick_m1;
   logic              w_any_req;
   logic              w_win_wr;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_wdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
   always_comb begin
      w_pick_m1 = bus.m1_req && !bus.m0_req;
   end
`else
   logic r_last_gnt;                // 0 = m0 granted last, 1 = m1 granted last

   // On a tie the requester that was not granted last wins.
   always_comb begin
      w_pick_m1 = bus.m1_req && (!bus.m0_req || !r_last_gnt);
   end
`endif

   always_comb begin
      w_any_req   = bus.m0_req || bus.m1_req;
      w_win_wr    = w_pick_m1 ? bus.m1_wr    : bus.m0_wr;
      w_win_addr  = w_pick_m1 ? bus.m1_addr  : bus.m0_addr;
      w_win_wdata = w_pick_m1 ? bus.m1_wdata : bus.m0_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_win         <= 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
`else
         r_last_gnt    <= 1'b1;     // m0 wins the first tie
`endif
         bus.m0_gnt    <= 1'b0;
         bus.m1_gnt    <= 1'b0;
         bus.m0_rvalid <= 1'b0;
         bus.m1_rvalid <= 1'b0;
         bus.m0_rdata  <= '0;
         bus.m1_rdata  <= '0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         bus.ram_wr    <= 1'b0;
      end else begin
         bus.m0_rvalid <= 1'b0;
         bus.m1_rvalid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  bus.ram_addr  <= w_win_addr;
                  bus.ram_wdata <= w_win_wdata;
                  bus.ram_wr    <= w_win_wr;
                  bus.m0_gnt    <= !w_pick_m1;
                  bus.m1_gnt    <= w_pick_m1;
                  r_win         <= w_pick_m1;
`ifdef RAM_ARB_FIXED_PRIO_EN
`else
                  r_last_gnt    <= w_pick_m1;
`endif
                  r_state       <= ACCESS;
               end
            end
            ACCESS: begin
               // ram_wr still holds the direction of this access
               bus.m0_gnt <= 1'b0;
               bus.m1_gnt <= 1'b0;
               bus.ram_wr <= 1'b0;
               r_state    <= bus.ram_wr ? IDLE : RESP;
            end
            RESP: begin
               if (r_win) begin
                  bus.m1_rdata  <= bus.ram_rdata;
                  bus.m1_rvalid <= 1'b1;
               end else begin
                  bus.m0_rdata  <= bus.ram_rdata;
                  bus.m0_rvalid <= 1'b1;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;
   localparam int AW = 11;
   localparam int DW = 32;
`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   // 2K x 32 RAM with registered read
   logic [DW-1:0] mem [2048];
   logic [DW-1:0] ram_q;
   always @(posedge clk) begin
      if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
      ram_q <= mem[bus.ram_addr];
   end
   assign bus.ram_rdata = ram_q;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("gnt_exclusive", 32'(bus.m0_gnt & bus.m1_gnt), 32'd0);
         check("rvalid_exclusive", 32'(bus.m0_rvalid & bus.m1_rvalid), 32'd0);
      end
   end

   task automatic idle_all();
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
   endtask

   task automatic drive(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin
         bus.m0_req = 1'b1; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = d;
      end else begin
         bus.m1_req = 1'b1; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = d;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_gnt"},    32'({bus.m1_gnt, bus.m0_gnt}), 32'd0);
      check({tag, "_rvalid"}, 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'd0);
      check({tag, "_ram_wr"}, 32'(bus.ram_wr), 32'd0);
      check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
      check({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
      check({tag, "_m0_rdata"}, bus.m0_rdata, 32'd0);
      check({tag, "_m1_rdata"}, bus.m1_rdata, 32'd0);
   endtask

   typedef struct {
      bit            m0_req;
      bit            m0_wr;
      logic [AW-1:0] m0_addr;
      logic [DW-1:0] m0_wdata;
      bit            m1_req;
      bit            m1_wr;
      logic [AW-1:0] m1_addr;
      logic [DW-1:0] m1_wdata;
      logic [1:0]    exp_gnt;     // {m1, m0}
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      bit            exp_wr;
      logic [DW-1:0] exp_rdata;   // winner's read result
   } vec_t;

   vec_t vt [8];

   initial begin
      logic [AW-1:0] pool [8];
      logic [DW-1:0] ref_mem [int];
      bit            m_last;
      int            order [$];

      vt[0] = '{1, 1, 11'h001, 32'h2000000B, 0, 0, 11'h000, 32'h0,
                2'b01, 11'h001, 32'h2000000B, 1, 32'h0};
      vt[1] = '{0, 0, 11'h000, 32'h0, 1, 0, 11'h001, 32'h11111111,
                2'b10, 11'h001, 32'h11111111, 0, 32'h2000000B};
      vt[2] = '{1, 1, 11'h000, 32'h12345678, 1, 1, 11'h7FF, 32'hDEADBEEF,
                2'b01, 11'h000, 32'h12345678, 1, 32'h0};
      vt[3] = '{0, 0, 11'h000, 32'h0, 1, 1, 11'h7FF, 32'hDEADBEEF,
                2'b10, 11'h7FF, 32'hDEADBEEF, 1, 32'h0};
      vt[4] = '{1, 0, 11'h000, 32'h0, 1, 0, 11'h7FF, 32'h0,
                2'b01, 11'h000, 32'h0, 0, 32'h12345678};
      vt[5] = '{0, 0, 11'h000, 32'h0, 1, 0, 11'h7FF, 32'h0,
                2'b10, 11'h7FF, 32'h0, 0, 32'hDEADBEEF};
      vt[6] = '{1, 1, 11'h010, 32'hA5A5A5A5, 1, 1, 11'h011, 32'h5A5A5A5A,
                2'b01, 11'h010, 32'hA5A5A5A5, 1, 32'h0};
      vt[7] = '{0, 0, 11'h000, 32'h0, 1, 1, 11'h011, 32'h5A5A5A5A,
                2'b10, 11'h011, 32'h5A5A5A5A, 1, 32'h0};

      bus.m0_req = 0; bus.m0_wr = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 0; bus.m1_wr = 0; bus.m1_addr = '0; bus.m1_wdata = '0;

      // reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;

      // table vectors: drive in IDLE, check the ACCESS cycle, then the response
      for (int i = 0; i < 8; i++) begin
         bus.m0_req = vt[i].m0_req; bus.m0_wr = vt[i].m0_wr;
         bus.m0_addr = vt[i].m0_addr; bus.m0_wdata = vt[i].m0_wdata;
         bus.m1_req = vt[i].m1_req; bus.m1_wr = vt[i].m1_wr;
         bus.m1_addr = vt[i].m1_addr; bus.m1_wdata = vt[i].m1_wdata;
         @(negedge clk);
         check($sformatf("vec%0d_gnt", i), 32'({bus.m1_gnt, bus.m0_gnt}), 32'(vt[i].exp_gnt));
         check($sformatf("vec%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vt[i].exp_addr));
         check($sformatf("vec%0d_ram_wdata", i), bus.ram_wdata, vt[i].exp_wdata);
         check($sformatf("vec%0d_ram_wr", i), 32'(bus.ram_wr), 32'(vt[i].exp_wr));
         idle_all();
         @(negedge clk);
         check($sformatf("vec%0d_gnt_pulse", i), 32'({bus.m1_gnt, bus.m0_gnt, bus.ram_wr}), 32'd0);
         if (!vt[i].exp_wr) begin
            check($sformatf("vec%0d_rvalid_early", i), 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_rvalid", i), 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(vt[i].exp_gnt));
            check($sformatf("vec%0d_rdata", i),
                  vt[i].exp_gnt[1] ? bus.m1_rdata : bus.m0_rdata, vt[i].exp_rdata);
         end
      end

      // reset during RESP of an m0 read
      drive(0, 1'b0, 11'h000, 32'h0);
      @(negedge clk);
      check("rstresp_gnt", 32'(bus.m0_gnt), 32'd1);
      idle_all();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("rstresp");
      rst_n = 1'b1;
      drive(0, 1'b0, 11'h7FF, 32'h0);
      @(negedge clk);
      check("post_rst_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd1);
      check("post_rst_addr", 32'(bus.ram_addr), 32'h7FF);
      idle_all();
      repeat (2) @(negedge clk);
      check("post_rst_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'd1);
      check("post_rst_rdata", bus.m0_rdata, 32'hDEADBEEF);

      // m1 request raised during ACCESS and dropped before IDLE sample
      drive(0, 1'b1, 11'h012, 32'h13579BDF);
      @(negedge clk);
      check("drop_m0_gnt", 32'(bus.m0_gnt), 32'd1);
      bus.m0_req = 1'b0;
      drive(1, 1'b1, 11'h011, 32'hBAD0BAD0);
      @(negedge clk);
      check("drop_m1_gnt_a", 32'(bus.m1_gnt), 32'd0);
      bus.m1_req = 1'b0;
      @(negedge clk);
      check("drop_m1_gnt_b", 32'({bus.m1_gnt, bus.ram_wr}), 32'd0);
      drive(1, 1'b0, 11'h011, 32'h0);
      @(negedge clk);
      check("drop_rb_gnt", 32'(bus.m1_gnt), 32'd1);
      idle_all();
      repeat (2) @(negedge clk);
      check("drop_rb_rvalid", 32'(bus.m1_rvalid), 32'd1);
      check("drop_rb_rdata", bus.m1_rdata, 32'h5A5A5A5A);

      // back-to-back m0 reads
      begin
         int n_rv = 0, n_g = 0;
         int t_rv [2] = '{0, 0};
         logic [DW-1:0] rdv [2] = '{32'h0, 32'h0};
         bit saw_wr = 1'b0;
         drive(0, 1'b0, 11'h010, 32'h0);
         for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.ram_wr) saw_wr = 1'b1;
            if (bus.m0_gnt) begin
               n_g++;
               if (n_g == 1) bus.m0_addr = 11'h011;
               else bus.m0_req = 1'b0;
            end
            if (bus.m0_rvalid && n_rv < 2) begin
               t_rv[n_rv] = c; rdv[n_rv] = bus.m0_rdata; n_rv++;
            end
         end
         idle_all();
         check("b2b_gnts", 32'(n_g), 32'd2);
         check("b2b_rvalids", 32'(n_rv), 32'd2);
         check("b2b_t0", 32'(t_rv[0]), 32'd3);
         check("b2b_t1", 32'(t_rv[1]), 32'd6);
         check("b2b_rdata0", rdv[0], 32'hA5A5A5A5);
         check("b2b_rdata1", rdv[1], 32'h5A5A5A5A);
         check("b2b_no_wr", 32'(saw_wr), 32'd0);
      end

      // randomized transactions against a transaction-level model
      pool = '{11'h000, 11'h7FF, 11'h123, 11'h456, 11'h3AB, 11'h001, 11'h400, 11'h2FF};
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1'b1;
      for (int k = 0; k < 68; k++) begin
         int mask, win;
         bit rw [2];
         logic [AW-1:0] ra [2];
         logic [DW-1:0] rd [2];
         mask = $urandom_range(1, 3);
         for (int p = 0; p < 2; p++) begin
            rw[p] = 1'($urandom_range(0, 1));
            ra[p] = pool[$urandom_range(0, 7)];
            rd[p] = $urandom;
         end
         if (k < 8) begin
            mask = 1; rw[0] = 1'b1; ra[0] = pool[k];
         end
         for (int p = 0; p < 2; p++)
            if (mask[p]) drive(p, rw[p], ra[p], rd[p]);
         if (mask == 3) win = FIXED ? 0 : (m_last ? 0 : 1);
         else win = (mask == 2) ? 1 : 0;
         m_last = (win == 1);
         @(negedge clk);
         check($sformatf("rnd%0d_gnt", k), 32'({bus.m1_gnt, bus.m0_gnt}), (win == 1) ? 32'd2 : 32'd1);
         check($sformatf("rnd%0d_addr", k), 32'(bus.ram_addr), 32'(ra[win]));
         check($sformatf("rnd%0d_wdata", k), bus.ram_wdata, rd[win]);
         check($sformatf("rnd%0d_wr", k), 32'(bus.ram_wr), 32'(rw[win]));
         idle_all();
         @(negedge clk);
         if (rw[win]) begin
            ref_mem[int'(ra[win])] = rd[win];
         end else begin
            @(negedge clk);
            check($sformatf("rnd%0d_rvalid", k), 32'({bus.m1_rvalid, bus.m0_rvalid}),
                  (win == 1) ? 32'd2 : 32'd1);
            if (ref_mem.exists(int'(ra[win])))
               check($sformatf("rnd%0d_rdata", k), (win == 1) ? bus.m1_rdata : bus.m0_rdata,
                     ref_mem[int'(ra[win])]);
         end
      end

      // both requesting continuously from reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1'b1, 11'h100, 32'h00000100);
      drive(1, 1'b1, 11'h101, 32'h00000101);
      for (int c = 0; c < 12 && order.size() < 4; c++) begin
         @(negedge clk);
         if (bus.m0_gnt) order.push_back(0);
         if (bus.m1_gnt) order.push_back(1);
      end
      idle_all();
      check("rr_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < order.size(); i++)
         check($sformatf("rr_order%0d", i), 32'(order[i]), FIXED ? 32'd0 : 32'(i % 2));
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
